// File: rtl/prog_sequencer.sv
// Microprogram sequencer: fetches {opcode, data} words from a small store and feeds the datapath.
// Optional single-step mode (PAUSE state, step input) is enabled by defining SEQ_SINGLE_STEP_EN.
module prog_sequencer #(
  parameter int unsigned AW  = 6,
  parameter int unsigned LAT = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [14:0]   ld_word,
  input  logic          start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic          step,
`endif
  output logic [9:0]    opcode_o,
  output logic [4:0]    data_o,
  output logic [AW-1:0] pc_o,
  output logic          busy,
  output logic          done,
  output logic          ld_err
);

  localparam int unsigned Depth = 1 << AW;
  localparam int unsigned HW    = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [9:0]  IdleOp = 10'h047;

`ifdef SEQ_SINGLE_STEP_EN
  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StIssue, StPause} state_e;
  localparam state_e NextSt = StPause;
`else
  typedef enum logic [1:0] {StIdle, StFetch, StDecode, StIssue} state_e;
  localparam state_e NextSt = StFetch;
`endif

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [5:0]    lc_q, lc_d;
  logic [5:0]    lc_dec;
  logic [HW-1:0] hold_q, hold_d;
  logic [9:0]    opcode_q, opcode_d;
  logic [4:0]    data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ld_err_q, ld_err_d;
  logic [14:0]   word_q;
  logic [3:0]    cls;

  logic [14:0] mem [Depth];

  // Store is deliberately left out of reset so a program survives an abort.
  always_ff @(posedge clk) begin
    if (ld_en && !busy_q) begin
      mem[ld_addr] <= ld_word;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StFetch) begin
      word_q <= mem[pc_q];
    end
  end

  assign cls    = word_q[14:11];
  assign lc_dec = lc_q - 6'd1;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    lc_d     = lc_q;
    hold_d   = hold_q;
    opcode_d = opcode_q;
    data_d   = data_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ld_err_d = ld_en && busy_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          pc_d    = '0;
          busy_d  = 1'b1;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        if (cls <= 4'd12) begin
          opcode_d = word_q[14:5];
          data_d   = word_q[4:0];
          hold_d   = '0;
          state_d  = StIssue;
        end else if (cls == 4'd13) begin
          // lc of 0 wraps to 63, so the branch is taken.
          lc_d    = lc_dec;
          pc_d    = (lc_dec != 6'd0) ? word_q[5 +: AW] : pc_q + AW'(1);
          state_d = NextSt;
        end else if (cls == 4'd14) begin
          lc_d    = word_q[10:5];
          pc_d    = pc_q + AW'(1);
          state_d = NextSt;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StIssue: begin
        hold_d = hold_q + HW'(1);
        if (hold_q == HW'(LAT - 1)) begin
          pc_d     = pc_q + AW'(1);
          opcode_d = IdleOp;
          data_d   = '0;
          state_d  = NextSt;
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      StPause: begin
        if (step) begin
          state_d = StFetch;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      lc_q     <= '0;
      hold_q   <= '0;
      opcode_q <= IdleOp;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      lc_q     <= lc_d;
      hold_q   <= hold_d;
      opcode_q <= opcode_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign opcode_o = opcode_q;
  assign data_o   = data_q;
  assign pc_o     = pc_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ld_err   = ld_err_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: directed and random programs checked cycle by cycle
// against a program-level interpreter of the instruction set.
module tb_prog_sequencer;

  localparam int Lat = 6;
  localparam logic [9:0] IdleOp = 10'h047;
  localparam logic [14:0] Halt = {10'h3C0, 5'd0};

  logic        clk, rst, ld_en, start;
  logic [5:0]  ld_addr;
  logic [14:0] ld_word;
  logic [9:0]  opcode_o;
  logic [4:0]  data_o;
  logic [5:0]  pc_o;
  logic        busy, done, ld_err;

  prog_sequencer #(.AW(6), .LAT(Lat)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_word(ld_word),
    .start(start), .opcode_o(opcode_o), .data_o(data_o), .pc_o(pc_o),
    .busy(busy), .done(done), .ld_err(ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference state
  logic [14:0] mdl_mem [64];
  int          mdl_lc;
  int          mdl_pc;
  bit          mdl_halted;
  logic [9:0]  exp_op[$];
  logic [4:0]  exp_data[$];
  bit          exp_dv[$];
  logic [5:0]  exp_pc[$];
  bit          exp_done[$];

  logic [9:0]  obs_op[$];
  logic [4:0]  obs_data[$];
  logic [5:0]  obs_pc[$];
  logic        obs_busy[$];
  logic        obs_done[$];

  function automatic void push_exp(logic [9:0] op, logic [4:0] d, bit dv, int pc, bit dn);
    exp_op.push_back(op);
    exp_data.push_back(d);
    exp_dv.push_back(dv);
    exp_pc.push_back(6'(pc));
    exp_done.push_back(dn);
  endfunction

  // Interprets the stored program: every instruction costs FETCH+DECODE, datapath ops add LAT
  // cycles of issue, and the cycle after HALT's decode shows done.
  task automatic model_run();
    int pc;
    logic [14:0] w;
    int cls;
    exp_op.delete(); exp_data.delete(); exp_dv.delete(); exp_pc.delete(); exp_done.delete();
    pc = 0;
    mdl_halted = 0;
    while (exp_op.size() < 3000) begin
      w = mdl_mem[pc];
      cls = int'(w[14:11]);
      repeat (2) push_exp(IdleOp, 5'd0, 0, pc, 0);
      if (cls == 15) begin
        mdl_halted = 1;
        mdl_pc = pc;
        push_exp(IdleOp, 5'd0, 0, pc, 1);
        break;
      end else if (cls <= 12) begin
        repeat (Lat) push_exp(w[14:5], w[4:0], 1, pc, 0);
        pc = (pc + 1) % 64;
      end else if (cls == 14) begin
        mdl_lc = int'(w[10:5]);
        pc = (pc + 1) % 64;
      end else begin
        mdl_lc = (mdl_lc + 63) % 64;
        pc = (mdl_lc != 0) ? int'(w[10:5]) : (pc + 1) % 64;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    mdl_lc = 0;
  endtask

  task automatic load_word(input int a, input logic [14:0] w);
    ld_en = 1'b1; ld_addr = 6'(a); ld_word = w;
    @(posedge clk); #1;
    ld_en = 1'b0;
    mdl_mem[a] = w;
  endtask

  // Pulses start (optionally with a same-cycle load) and records every cycle until done.
  task automatic run_prog(input int budget, input bit do_ld, input int a, input logic [14:0] w);
    obs_op.delete(); obs_data.delete(); obs_pc.delete(); obs_busy.delete(); obs_done.delete();
    start = 1'b1;
    if (do_ld) begin
      ld_en = 1'b1; ld_addr = 6'(a); ld_word = w; mdl_mem[a] = w;
    end
    @(posedge clk); #1;
    start = 1'b0; ld_en = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      obs_op.push_back(opcode_o); obs_data.push_back(data_o); obs_pc.push_back(pc_o);
      obs_busy.push_back(busy); obs_done.push_back(done);
      if (done === 1'b1) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_chk += 6;
    if (opcode_o !== IdleOp) begin n_fail++; $display("FAIL reset_opcode: got %h, required %h", opcode_o, IdleOp); end
    if (data_o !== 5'd0)     begin n_fail++; $display("FAIL reset_data: got %0d, required 0", data_o); end
    if (pc_o !== 6'd0)       begin n_fail++; $display("FAIL reset_pc: got %0d, required 0", pc_o); end
    if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
    if (ld_err !== 1'b0)     begin n_fail++; $display("FAIL reset_ld_err: got %b, required 0", ld_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_dp_halt();
    load_word(0, {10'h069, 5'd3});
    load_word(1, Halt);
    model_run();
    run_prog(exp_op.size() + 10, 0, 0, '0);
    for (int i = 0; i < exp_op.size(); i++) begin
      n_chk++;
      if (i >= obs_op.size()) begin n_fail++; $display("FAIL dp_halt cycle %0d: no sample, required done", i); break; end
      if (obs_op[i] !== exp_op[i] || obs_pc[i] !== exp_pc[i] || obs_done[i] !== exp_done[i] ||
          obs_busy[i] !== !exp_done[i] || (exp_dv[i] && obs_data[i] !== exp_data[i])) begin
        n_fail++;
        $display("FAIL dp_halt cycle %0d: got op=%h data=%0d pc=%0d busy=%b done=%b, required op=%h data=%0d pc=%0d done=%b",
                 i, obs_op[i], obs_data[i], obs_pc[i], obs_busy[i], obs_done[i], exp_op[i], exp_data[i], exp_pc[i], exp_done[i]);
        break;
      end
    end
    n_chk++;
    if (obs_op.size() != 11 || obs_done[10] !== 1'b1 || obs_pc[10] !== 6'd1) begin
      n_fail++; $display("FAIL dp_halt_done_cycle: got %0d samples, required done at T+11 with pc 1", obs_op.size());
    end
  endtask

  task automatic test_loop_count();
    int windows;
    load_word(0, {10'h383, 5'd0});
    load_word(1, {10'h069, 5'd1});
    load_word(2, {10'h341, 5'd0});
    mdl_mem[3] = Halt;  // written in the same cycle as start
    model_run();
    run_prog(exp_op.size() + 10, 1, 3, Halt);
    for (int i = 0; i < exp_op.size(); i++) begin
      n_chk++;
      if (i >= obs_op.size()) begin n_fail++; $display("FAIL loop cycle %0d: no sample, required done", i); break; end
      if (obs_op[i] !== exp_op[i] || obs_pc[i] !== exp_pc[i] || obs_done[i] !== exp_done[i] ||
          obs_busy[i] !== !exp_done[i] || (exp_dv[i] && obs_data[i] !== exp_data[i])) begin
        n_fail++;
        $display("FAIL loop cycle %0d: got op=%h data=%0d pc=%0d done=%b, required op=%h data=%0d pc=%0d done=%b",
                 i, obs_op[i], obs_data[i], obs_pc[i], obs_done[i], exp_op[i], exp_data[i], exp_pc[i], exp_done[i]);
        break;
      end
    end
    windows = 0;
    for (int i = 0; i < obs_op.size(); i++)
      if (obs_op[i] === 10'h069 && (i == 0 || obs_op[i-1] !== 10'h069)) windows++;
    n_chk += 2;
    if (windows != 3) begin n_fail++; $display("FAIL loop_windows: got %0d, required 3", windows); end
    if (dut.lc_q !== 6'd0) begin n_fail++; $display("FAIL loop_lc: got %0d, required 0", dut.lc_q); end
  endtask

  task automatic test_djnz_zero();
    do_reset();
    load_word(0, {10'h345, 5'd0});
    load_word(5, Halt);
    model_run();
    run_prog(exp_op.size() + 10, 0, 0, '0);
    for (int i = 0; i < exp_op.size(); i++) begin
      n_chk++;
      if (i >= obs_op.size()) begin n_fail++; $display("FAIL djnz0 cycle %0d: no sample, required done", i); break; end
      if (obs_op[i] !== exp_op[i] || obs_pc[i] !== exp_pc[i] || obs_done[i] !== exp_done[i]) begin
        n_fail++;
        $display("FAIL djnz0 cycle %0d: got op=%h pc=%0d done=%b, required op=%h pc=%0d done=%b",
                 i, obs_op[i], obs_pc[i], obs_done[i], exp_op[i], exp_pc[i], exp_done[i]);
        break;
      end
    end
    n_chk += 2;
    if (pc_o !== 6'd5) begin n_fail++; $display("FAIL djnz0_pc: got %0d, required 5", pc_o); end
    if (dut.lc_q !== 6'd63) begin n_fail++; $display("FAIL djnz0_lc: got %0d, required 63", dut.lc_q); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    load_word(0, {10'h37F, 5'd0});  // DJNZ -> 63, lc starts at 0 so 63 passes
    load_word(1, Halt);
    load_word(63, {10'h069, 5'd2});
    model_run();
    run_prog(exp_op.size() + 10, 0, 0, '0);
    for (int i = 0; i < exp_op.size(); i++) begin
      n_chk++;
      if (i >= obs_op.size()) begin n_fail++; $display("FAIL wrap cycle %0d: no sample, required done", i); break; end
      if (obs_op[i] !== exp_op[i] || obs_pc[i] !== exp_pc[i] || obs_done[i] !== exp_done[i] ||
          (exp_dv[i] && obs_data[i] !== exp_data[i])) begin
        n_fail++;
        $display("FAIL wrap cycle %0d: got op=%h pc=%0d done=%b, required op=%h pc=%0d done=%b",
                 i, obs_op[i], obs_pc[i], obs_done[i], exp_op[i], exp_pc[i], exp_done[i]);
        break;
      end
    end
  endtask

  task automatic test_reset_mid_issue();
    load_word(0, {10'h069, 5'd3});
    load_word(1, Halt);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;                          // now in T+1
    repeat (4) begin @(posedge clk); #1; end  // T+5, third hold cycle
    @(negedge clk);
    n_chk++;
    if (opcode_o !== 10'h069) begin n_fail++; $display("FAIL rst_mid_pre: got %h, required 069", opcode_o); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_lc = 0;
    @(negedge clk);
    n_chk += 3;
    if (opcode_o !== IdleOp) begin n_fail++; $display("FAIL rst_mid_op: got %h, required %h", opcode_o, IdleOp); end
    if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_mid_busy: got %b, required 0", busy); end
    if (pc_o !== 6'd0)       begin n_fail++; $display("FAIL rst_mid_pc: got %0d, required 0", pc_o); end
    @(posedge clk); #1;
    model_run();
    run_prog(exp_op.size() + 10, 0, 0, '0);
    for (int i = 0; i < exp_op.size(); i++) begin
      n_chk++;
      if (i >= obs_op.size()) begin n_fail++; $display("FAIL rst_rerun cycle %0d: no sample, required done", i); break; end
      if (obs_op[i] !== exp_op[i] || obs_pc[i] !== exp_pc[i] || obs_done[i] !== exp_done[i]) begin
        n_fail++;
        $display("FAIL rst_rerun cycle %0d: got op=%h pc=%0d done=%b, required op=%h pc=%0d done=%b",
                 i, obs_op[i], obs_pc[i], obs_done[i], exp_op[i], exp_pc[i], exp_done[i]);
        break;
      end
    end
  endtask

  task automatic test_load_busy();
    bit seen;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;                          // T+1
    repeat (3) begin @(posedge clk); #1; end  // T+4, inside ISSUE
    ld_en = 1'b1; ld_addr = 6'd1; ld_word = {10'h0AA, 5'd7};
    @(posedge clk); #1;
    ld_en = 1'b0;
    @(negedge clk);
    n_chk++;
    if (ld_err !== 1'b1) begin n_fail++; $display("FAIL ld_err_pulse: got %b, required 1", ld_err); end
    @(negedge clk);
    n_chk++;
    if (ld_err !== 1'b0) begin n_fail++; $display("FAIL ld_err_width: got %b, required 0", ld_err); end
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); seen = (done === 1'b1); end
    n_chk++;
    if (!seen) begin n_fail++; $display("FAIL ld_busy_done: got no done in 40 cycles, required done"); end
    @(posedge clk); #1;
    model_run();  // store[1] must still hold HALT
    run_prog(exp_op.size() + 10, 0, 0, '0);
    for (int i = 0; i < exp_op.size(); i++) begin
      n_chk++;
      if (i >= obs_op.size()) begin n_fail++; $display("FAIL ld_busy_rerun cycle %0d: no sample, required done", i); break; end
      if (obs_op[i] !== exp_op[i] || obs_pc[i] !== exp_pc[i] || obs_done[i] !== exp_done[i]) begin
        n_fail++;
        $display("FAIL ld_busy_rerun cycle %0d: got op=%h pc=%0d done=%b, required op=%h pc=%0d done=%b",
                 i, obs_op[i], obs_pc[i], obs_done[i], exp_op[i], exp_pc[i], exp_done[i]);
        break;
      end
    end
  endtask

  task automatic test_random();
    int saved_lc;
    for (int p = 0; p < 4; p++) begin
      saved_lc = mdl_lc;
      for (int tries = 0; tries < 50; tries++) begin
        for (int a = 0; a < 64; a++) mdl_mem[a] = 15'($urandom);
        mdl_lc = saved_lc;
        model_run();
        if (mdl_halted) break;
      end
      if (!mdl_halted) continue;
      for (int a = 0; a < 64; a++) load_word(a, mdl_mem[a]);
      run_prog(exp_op.size() + 10, 0, 0, '0);
      for (int i = 0; i < exp_op.size(); i++) begin
        n_chk++;
        if (i >= obs_op.size()) begin n_fail++; $display("FAIL rand%0d cycle %0d: no sample, required done", p, i); break; end
        if (obs_op[i] !== exp_op[i] || obs_pc[i] !== exp_pc[i] || obs_done[i] !== exp_done[i] ||
            obs_busy[i] !== !exp_done[i] || (exp_dv[i] && obs_data[i] !== exp_data[i])) begin
          n_fail++;
          $display("FAIL rand%0d cycle %0d: got op=%h data=%0d pc=%0d done=%b, required op=%h data=%0d pc=%0d done=%b",
                   p, i, obs_op[i], obs_data[i], obs_pc[i], obs_done[i], exp_op[i], exp_data[i], exp_pc[i], exp_done[i]);
          break;
        end
      end
      n_chk++;
      if (dut.lc_q !== 6'(mdl_lc)) begin n_fail++; $display("FAIL rand%0d_lc: got %0d, required %0d", p, dut.lc_q, mdl_lc); end
    end
  endtask

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_word = '0; start = 1'b0;
    mdl_lc = 0;
    for (int a = 0; a < 64; a++) mdl_mem[a] = 'x;
    @(posedge clk); #1;
    test_reset();
    test_dp_halt();
    test_loop_count();
    test_djnz_zero();
    test_pc_wrap();
    test_reset_mid_issue();
    test_load_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
